filter_peak_ctrl: RTL and testbench

Event controller downstream of the trapezoidal shaping filter. Arms on the shaped stream and tracks each pulse above a programmable threshold. Captures peak amplitude and peak timestamp, and enforces dead time and track timeout. Hands one event at a time to the readout logic over a valid/ready handshake.

---
 rtl/filter_peak_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_filter_peak_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/filter_peak_ctrl.sv
// filter_peak_ctrl: event controller behind the trapezoidal shaping filter.
// It arms on the shaped stream and tracks each pulse that rises above the
// threshold. It records the peak amplitude and the timestamp of the peak,
// then applies dead time and a track timeout. Events go to readout over a
// valid/ready handshake.
// Optional build macro: FILTER_PEAK_CTRL_BASELINE_EN adds a slow baseline
// estimator. Every compare and the peak itself then use the corrected sample.
module filter_peak_ctrl #(
    parameter int SIZE_FILTER_DATA = 16,
    parameter int TS_WIDTH         = 32,
    parameter int DEAD_TIME        = 16,
    parameter int MAX_TRACK        = 256,
    parameter int DROP_WIDTH       = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
    input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
    output logic                               evt_valid,
    input  logic                               evt_ready,
    output logic signed [SIZE_FILTER_DATA-1:0] evt_amplitude,
    output logic        [TS_WIDTH-1:0]         evt_timestamp,
    output logic                               evt_pileup,
    output logic                               busy,
    output logic        [DROP_WIDTH-1:0]       dropped_count
);

    localparam int DW     = SIZE_FILTER_DATA;
    localparam int TRK_W  = $clog2(MAX_TRACK + 1);
    localparam int DEAD_W = $clog2(DEAD_TIME + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_TRACK = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [TS_WIDTH-1:0]    ts_q, ts_d;
    logic signed [DW-1:0]   peak_q, peak_d;
    logic [TS_WIDTH-1:0]    peak_ts_q, peak_ts_d;
    logic [TRK_W-1:0]       trk_cnt_q, trk_cnt_d;
    logic [DEAD_W-1:0]      dead_cnt_q, dead_cnt_d;
    logic                   evt_valid_q, evt_valid_d;
    logic signed [DW-1:0]   evt_amp_q, evt_amp_d;
    logic [TS_WIDTH-1:0]    evt_ts_q, evt_ts_d;
    logic                   evt_pileup_q, evt_pileup_d;
    logic                   busy_q, busy_d;
    logic [DROP_WIDTH-1:0]  dropped_q, dropped_d;

    logic signed [DW-1:0]   x_corr;
    logic                   above_thr;
    logic                   close_evt;
    logic                   close_pileup;

`ifdef FILTER_PEAK_CTRL_BASELINE_EN
    // The baseline has 4 fractional bits. Its integer part is subtracted from the raw sample.
    logic signed [DW+3:0]   bl_q, bl_d;
    logic signed [DW-1:0]   bl_int;
    logic signed [DW:0]     x_diff;
    logic signed [DW+4:0]   bl_err;
    logic signed [DW+4:0]   bl_step;

    // Corrected sample, saturated back into the filter data width.
    always_comb begin
        bl_int = bl_q[DW+3:4];
        x_diff = {filter_data[DW-1], filter_data} - {bl_int[DW-1], bl_int};
        if (x_diff[DW] != x_diff[DW-1]) begin
            x_corr = x_diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            x_corr = x_diff[DW-1:0];
        end
    end

    // First-order baseline follower. It only learns while waiting for a pulse.
    always_comb begin
        bl_err  = {filter_data[DW-1], filter_data, 4'b0000} - {bl_q[DW+3], bl_q};
        bl_step = bl_err >>> 4;
        bl_d    = bl_q;
        if (enable && state_q == S_ARMED) begin
            bl_d = bl_q + bl_step[DW+3:0];
        end
    end

    // Baseline register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bl_q <= '0;
        end else begin
            bl_q <= bl_d;
        end
    end
`else
    // With no baseline estimator, the sample is used as it arrives.
    always_comb begin
        x_corr = filter_data;
    end
`endif

    assign above_thr = (x_corr > threshold);

    // Next-state logic for the FSM, the timestamp, the peak tracker and the event register.
    always_comb begin
        state_d      = state_q;
        ts_d         = ts_q;
        peak_d       = peak_q;
        peak_ts_d    = peak_ts_q;
        trk_cnt_d    = trk_cnt_q;
        dead_cnt_d   = dead_cnt_q;
        evt_valid_d  = evt_valid_q;
        evt_amp_d    = evt_amp_q;
        evt_ts_d     = evt_ts_q;
        evt_pileup_d = evt_pileup_q;
        dropped_d    = dropped_q;
        close_evt    = 1'b0;
        close_pileup = 1'b0;

        if (enable) begin
            ts_d = ts_q + 1'b1;
        end

        if (!enable) begin
            // A disabled controller drops any track in progress.
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (above_thr) begin
                        state_d   = S_TRACK;
                        peak_d    = x_corr;
                        peak_ts_d = ts_q;
                        trk_cnt_d = TRK_W'(1);
                    end
                end
                S_TRACK: begin
                    if (trk_cnt_q == TRK_W'(MAX_TRACK)) begin
                        // Timeout has priority. This sample does not count toward the peak.
                        close_evt    = 1'b1;
                        close_pileup = 1'b1;
                    end else if (!above_thr) begin
                        close_evt = 1'b1;
                    end else begin
                        trk_cnt_d = trk_cnt_q + 1'b1;
                        // Strict compare, so the earliest of equal maxima is kept.
                        if (x_corr > peak_q) begin
                            peak_d    = x_corr;
                            peak_ts_d = ts_q;
                        end
                    end
                    if (close_evt) begin
                        state_d    = S_DEAD;
                        dead_cnt_d = DEAD_W'(DEAD_TIME);
                    end
                end
                S_DEAD: begin
                    if (dead_cnt_q == DEAD_W'(1)) begin
                        // Re-arm only once the signal is back below threshold.
                        if (!above_thr) begin
                            state_d = S_ARMED;
                        end
                    end else begin
                        dead_cnt_d = dead_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Handshake. A closing event may load in the same cycle the consumer takes the old one.
        if (evt_ready) begin
            evt_valid_d = 1'b0;
        end
        if (close_evt) begin
            if (!evt_valid_q || evt_ready) begin
                evt_valid_d  = 1'b1;
                evt_amp_d    = peak_q;
                evt_ts_d     = peak_ts_q;
                evt_pileup_d = close_pileup;
            end else if (dropped_q != {DROP_WIDTH{1'b1}}) begin
                dropped_d = dropped_q + 1'b1;
            end
        end

        busy_d = (state_d == S_TRACK) || (state_d == S_DEAD);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ts_q         <= '0;
            peak_q       <= '0;
            peak_ts_q    <= '0;
            trk_cnt_q    <= '0;
            dead_cnt_q   <= '0;
            evt_valid_q  <= 1'b0;
            evt_amp_q    <= '0;
            evt_ts_q     <= '0;
            evt_pileup_q <= 1'b0;
            busy_q       <= 1'b0;
            dropped_q    <= '0;
        end else begin
            state_q      <= state_d;
            ts_q         <= ts_d;
            peak_q       <= peak_d;
            peak_ts_q    <= peak_ts_d;
            trk_cnt_q    <= trk_cnt_d;
            dead_cnt_q   <= dead_cnt_d;
            evt_valid_q  <= evt_valid_d;
            evt_amp_q    <= evt_amp_d;
            evt_ts_q     <= evt_ts_d;
            evt_pileup_q <= evt_pileup_d;
            busy_q       <= busy_d;
            dropped_q    <= dropped_d;
        end
    end

    assign evt_valid     = evt_valid_q;
    assign evt_amplitude = evt_amp_q;
    assign evt_timestamp = evt_ts_q;
    assign evt_pileup    = evt_pileup_q;
    assign busy          = busy_q;
    assign dropped_count = dropped_q;

endmodule

// File: tb/tb_filter_peak_ctrl.sv
// Directed testbench for filter_peak_ctrl. Parameters: DEAD_TIME=4, MAX_TRACK=8, threshold 100.
module tb_filter_peak_ctrl;

    logic               clk;
    logic               reset;
    logic               enable;
    logic signed [15:0] threshold;
    logic signed [15:0] filter_data;
    logic               evt_valid;
    logic               evt_ready;
    logic [15:0]        evt_amplitude;
    logic [31:0]        evt_timestamp;
    logic               evt_pileup;
    logic               busy;
    logic [15:0]        dropped_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] tb_ts    = 0;   // timestamp the DUT should hold
    logic [31:0] last_tag = 0;   // timestamp of the most recent sample
    logic [31:0] exp_ts;

    filter_peak_ctrl #(
        .SIZE_FILTER_DATA(16),
        .TS_WIDTH(32),
        .DEAD_TIME(4),
        .MAX_TRACK(8),
        .DROP_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .threshold(threshold),
        .filter_data(filter_data),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_amplitude(evt_amplitude),
        .evt_timestamp(evt_timestamp),
        .evt_pileup(evt_pileup),
        .busy(busy),
        .dropped_count(dropped_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Drive one sample, clock it in and record its timestamp. Outputs are sampled 1 ns after the edge.
    task automatic step(input logic signed [15:0] x);
        filter_data = x;
        @(posedge clk);
        last_tag = tb_ts;
        if (enable) tb_ts = tb_ts + 1;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        enable      = 1'b0;
        evt_ready   = 1'b0;
        threshold   = 16'sd100;
        filter_data = 16'sd0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dropped", 32'(dropped_count), 32'd0);
        reset = 1'b1;
        tb_ts = 0;

        // Single pulse. The 300 sample is tagged ts=12.
        enable    = 1'b1;
        evt_ready = 1'b1;
        for (int i = 0; i < 10; i++) step(16'sd0);
        step(16'sd50);
        step(16'sd150);
        check("p1_busy_trk", 32'(busy), 32'd1);
        step(16'sd300);
        step(16'sd250);
        step(16'sd120);
        step(16'sd80);
        check("p1_valid", 32'(evt_valid), 32'd1);
        check("p1_amp", 32'(evt_amplitude), 32'd300);
        check("p1_ts", evt_timestamp, 32'd12);
        check("p1_pileup", 32'(evt_pileup), 32'd0);
        step(16'sd0);
        check("p1_valid_1cyc", 32'(evt_valid), 32'd0);
        step(16'sd0);
        step(16'sd0);
        check("p1_busy_dead", 32'(busy), 32'd1);
        step(16'sd0);
        check("p1_busy_rearm", 32'(busy), 32'd0);

        // Backpressure: the second event is dropped and the first one is held.
        evt_ready = 1'b0;
        step(16'sd150);
        step(16'sd300);
        exp_ts = last_tag;
        step(16'sd150);
        step(16'sd0);
        check("bp_valid1", 32'(evt_valid), 32'd1);
        for (int i = 0; i < 5; i++) step(16'sd0);
        step(16'sd150);
        step(16'sd400);
        step(16'sd150);
        step(16'sd0);
        check("bp_dropped", 32'(dropped_count), 32'd1);
        check("bp_amp_held", 32'(evt_amplitude), 32'd300);
        check("bp_ts_held", evt_timestamp, exp_ts);
        check("bp_valid_held", 32'(evt_valid), 32'd1);
        step(16'sd0);
        evt_ready = 1'b1;
        step(16'sd0);
        check("bp_valid_clr", 32'(evt_valid), 32'd0);
        step(16'sd0);
        step(16'sd0);

        // Timeout: a constant 200 input closes with pileup after MAX_TRACK cycles.
        for (int i = 0; i < 20; i++) begin
            step(16'sd200);
            if (i == 0) exp_ts = last_tag;
            if (i == 8) begin
                check("to_valid", 32'(evt_valid), 32'd1);
                check("to_pileup", 32'(evt_pileup), 32'd1);
                check("to_amp", 32'(evt_amplitude), 32'd200);
                check("to_ts", evt_timestamp, exp_ts);
            end
        end
        check("to_dead_busy", 32'(busy), 32'd1);
        check("to_no_second", 32'(evt_valid), 32'd0);
        step(16'sd0);
        check("to_rearm", 32'(busy), 32'd0);

        // Signed compare
        for (int i = 0; i < 10; i++) step(-16'sd500);
        check("sg_no_trig", 32'(busy), 32'd0);
        check("sg_no_evt", 32'(evt_valid), 32'd0);
        threshold = -16'sd600;
        step(-16'sd500);
        check("sg_trig", 32'(busy), 32'd1);
        step(-16'sd700);
        check("sg_valid", 32'(evt_valid), 32'd1);
        check("sg_amp", 32'(evt_amplitude), 32'h0000FE0C);
        threshold = 16'sd100;
        for (int i = 0; i < 5; i++) step(16'sd0);

        // Enable abort while tracking. Timestamps freeze while disabled.
        step(16'sd150);
        step(16'sd300);
        enable = 1'b0;
        step(16'sd300);
        check("en_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) step(16'sd300);
        check("en_no_evt", 32'(evt_valid), 32'd0);
        check("en_idle", 32'(busy), 32'd0);
        enable = 1'b1;
        step(16'sd0);
        step(16'sd0);
        step(16'sd150);
        step(16'sd300);
        exp_ts = last_tag;
        step(16'sd0);
        check("en_valid", 32'(evt_valid), 32'd1);
        check("en_ts", evt_timestamp, exp_ts);
        check("en_amp", 32'(evt_amplitude), 32'd300);

        // Asynchronous reset in the middle of a track while an event is pending.
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) step(16'sd0);
        step(16'sd150);
        check("rs_pre_busy", 32'(busy), 32'd1);
        check("rs_pre_valid", 32'(evt_valid), 32'd1);
        reset = 1'b0;
        #2;
        check("rs_valid", 32'(evt_valid), 32'd0);
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_dropped", 32'(dropped_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        tb_ts = 0;
        step(16'sd0);
        step(16'sd0);
        step(16'sd150);
        step(16'sd300);
        step(16'sd0);
        check("rs_ts_restart", evt_timestamp, 32'd3);
        check("rs_amp", 32'(evt_amplitude), 32'd300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
